// File: rtl/lcd_layer_arbiter_pkg.sv
// Shared widths, state encoding and default colour for the LCD pixel-source arbiter.
package lcd_pkg;
    localparam int COLOR_W = 16;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;

    localparam logic [COLOR_W-1:0] DEFAULT_BG_COLOR = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/lcd_layer_arbiter_if.sv
// Shared request/acknowledge bus between the arbiter and its layer generators.
interface lcd_layer_arbiter_if #(
    parameter int NUM_LAYERS = 3
);
    import lcd_pkg::*;

    logic [NUM_LAYERS-1:0]         layer_req;
    logic [X_W-1:0]                layer_x;
    logic [Y_W-1:0]                layer_y;
    logic [NUM_LAYERS-1:0]         layer_ack;
    logic [NUM_LAYERS-1:0]         layer_opaque;
    logic [COLOR_W*NUM_LAYERS-1:0] layer_color;

    modport master (
        output layer_req, layer_x, layer_y,
        input  layer_ack, layer_opaque, layer_color
    );

    modport slave (
        input  layer_req, layer_x, layer_y,
        output layer_ack, layer_opaque, layer_color
    );
endinterface

// File: rtl/lcd_layer_arbiter_rise_detect.sv
// Registered rising-edge detector for the driver's next_pixel request level.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);
    logic r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/lcd_layer_arbiter.sv
// Per-pixel layer scheduler: polls layers in priority order and returns the first opaque colour.
//   state | meaning
//   IDLE  | waiting for a pixel request (new edge or pending)
//   REQ   | querying layer r_idx, timeout counter running
//   DONE  | result just published, return to IDLE
module lcd_layer_arbiter
    import lcd_pkg::*;
#(
    parameter int                 NUM_LAYERS = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR   = DEFAULT_BG_COLOR,
    parameter int                 TIMEOUT    = 15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [X_W-1:0]     i_x,
    input  logic [Y_W-1:0]     i_y,
    input  logic               i_next_pixel,
    output logic [COLOR_W-1:0] o_color,
    output logic               o_color_done,
    output logic               o_frame_start,
    output logic [15:0]        o_frame_count,
    output logic               o_busy,
    output logic               o_overrun,
    lcd_layer_arbiter_if.master lyr
);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pending;
    logic               w_req;
    logic               w_ack;
    logic               w_opq;
    logic [COLOR_W-1:0] w_sel_color;

    rise_detect u_rise (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_next_pixel),
        .o_rise (w_req)
    );

    assign w_ack       = lyr.layer_ack[r_idx];
    assign w_opq       = lyr.layer_opaque[r_idx];
    assign w_sel_color = lyr.layer_color[r_idx*COLOR_W +: COLOR_W];

    // Combinational so that an asynchronous reset drops the strobe immediately.
    assign lyr.layer_req = (r_state == S_REQ) ? (NUM_LAYERS'(1) << r_idx) : '0;
    assign o_busy        = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            o_color       <= '0;
            o_color_done  <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_count <= '0;
            o_overrun     <= 1'b0;
            lyr.layer_x   <= '0;
            lyr.layer_y   <= '0;
        end else begin
            o_color_done  <= 1'b0;
            o_frame_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pending || w_req) begin
                        lyr.layer_x <= i_x;
                        lyr.layer_y <= i_y;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                        r_state     <= S_REQ;
                        // A fresh edge arriving while a pending one is consumed stays queued.
                        r_pending   <= r_pending & w_req;
                        if (i_x == '0 && i_y == '0) begin
                            o_frame_start <= 1'b1;
                            o_frame_count <= o_frame_count + 16'd1;
                        end
                    end
                end
                S_REQ: begin
                    if (w_ack && w_opq) begin
                        o_color      <= w_sel_color;
                        o_color_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (w_ack || r_cnt == CNT_MAX) begin
                        if (r_idx == LAST_IDX) begin
                            o_color      <= BG_COLOR;
                            o_color_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_cnt <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (r_state != S_IDLE && w_req) begin
                if (r_pending) begin
                    o_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_layer_arbiter.sv
// Directed vector bench for lcd_layer_arbiter with a delay-programmable layer model.
module tb_lcd_layer_arbiter;
    import lcd_pkg::*;

    localparam int NL = 3;
    localparam int TO = 15;

    typedef struct {
        logic [7:0]       x;
        logic [6:0]       y;
        logic [2:0][7:0]  dly;
        logic [2:0]       opq;
        logic [2:0]       stray;
        logic [2:0][15:0] col;
        logic [15:0]      exp_color;
        int               exp_lat;
        logic [2:0]       exp_mask;
        logic             exp_fs;
        logic [15:0]      exp_fc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic        np = 1'b0;
    logic [15:0] color;
    logic        color_done;
    logic        frame_start;
    logic [15:0] frame_count;
    logic        busy;
    logic        overrun;

    logic [2:0][7:0]  m_dly   = {8'hFF, 8'hFF, 8'hFF};
    logic [2:0]       m_opq   = '0;
    logic [2:0]       m_stray = '0;
    logic [2:0][15:0] m_col   = '0;
    int               age [NL];

    int n_vec = 0;
    int n_err = 0;

    lcd_layer_arbiter_if #(.NUM_LAYERS(NL)) lyr ();

    lcd_layer_arbiter #(
        .NUM_LAYERS (NL),
        .BG_COLOR   (16'h0000),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_x           (x),
        .i_y           (y),
        .i_next_pixel  (np),
        .o_color       (color),
        .o_color_done  (color_done),
        .o_frame_start (frame_start),
        .o_frame_count (frame_count),
        .o_busy        (busy),
        .o_overrun     (overrun),
        .lyr           (lyr)
    );

    always #5 clk = ~clk;

    // Layer i acks m_dly[i] cycles after its req rises (8'hFF = never); stray layers ack constantly.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NL; i++) begin
            if (rst)                    age[i] <= 0;
            else if (lyr.layer_req[i])  age[i] <= age[i] + 1;
            else                        age[i] <= 0;
        end
    end

    always_comb begin
        lyr.layer_ack    = '0;
        lyr.layer_opaque = m_opq;
        lyr.layer_color  = m_col;
        for (int i = 0; i < NL; i++) begin
            lyr.layer_ack[i] = m_stray[i] |
                (lyr.layer_req[i] && m_dly[i] != 8'hFF && age[i] == int'(m_dly[i]));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a request edge; returns #1 after the edge at which the arbiter captures it.
    task automatic request(input logic [7:0] px, input logic [6:0] py);
        @(negedge clk);
        x  = px;
        y  = py;
        np = 1'b1;
        @(posedge clk);
        #1;
        np = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat, output logic [2:0] mask);
        lat  = 0;
        mask = lyr.layer_req;
        while (lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
            if (color_done) break;
            mask |= lyr.layer_req;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [8];
        int          lat;
        logic [2:0]  mask;
        logic        found;

        vecs[0] = '{8'd10, 7'd20, {8'hFF, 8'hFF, 8'd0}, 3'b001, 3'b000,
                    {16'h0, 16'h0, 16'hF800}, 16'hF800, 1, 3'b001, 1'b0, 16'd0};
        vecs[1] = '{8'd3, 7'd4, {8'd1, 8'd2, 8'd2}, 3'b100, 3'b000,
                    {16'h07E0, 16'h0, 16'h0}, 16'h07E0, 8, 3'b111, 1'b0, 16'd0};
        vecs[2] = '{8'd30, 7'd40, {8'hFF, 8'hFF, 8'hFF}, 3'b000, 3'b000,
                    {16'h0, 16'h0, 16'h0}, 16'h0000, 48, 3'b111, 1'b0, 16'd0};
        vecs[3] = '{8'd0, 7'd0, {8'hFF, 8'hFF, 8'd1}, 3'b001, 3'b000,
                    {16'h0, 16'h0, 16'h001F}, 16'h001F, 2, 3'b001, 1'b1, 16'd1};
        vecs[4] = '{8'd0, 7'd0, {8'hFF, 8'd3, 8'hFF}, 3'b010, 3'b000,
                    {16'h0, 16'hABCD, 16'h0}, 16'hABCD, 20, 3'b011, 1'b1, 16'd2};
        vecs[5] = '{8'd5, 7'd3, {8'd0, 8'd0, 8'd0}, 3'b100, 3'b000,
                    {16'h1234, 16'h0, 16'h0}, 16'h1234, 3, 3'b111, 1'b0, 16'd2};
        vecs[6] = '{8'd6, 7'd6, {8'd0, 8'hFF, 8'd4}, 3'b111, 3'b110,
                    {16'hBEEF, 16'hBEEF, 16'h5555}, 16'h5555, 5, 3'b001, 1'b0, 16'd2};
        vecs[7] = '{8'd7, 7'd8, {8'd0, 8'd0, 8'd0}, 3'b000, 3'b000,
                    {16'hAAAA, 16'hBBBB, 16'hCCCC}, 16'h0000, 3, 3'b111, 1'b0, 16'd2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_color", color, 16'h0000);
        check("rst_done", color_done, 1'b0);
        check("rst_req", lyr.layer_req, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_fcount", frame_count, 16'd0);
        check("rst_overrun", overrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            m_dly   = vecs[v].dly;
            m_opq   = vecs[v].opq;
            m_stray = vecs[v].stray;
            m_col   = vecs[v].col;
            request(vecs[v].x, vecs[v].y);
            check($sformatf("v%0d_busy", v), busy, 1'b1);
            check($sformatf("v%0d_req0", v), lyr.layer_req, 3'b001);
            check($sformatf("v%0d_fstart", v), frame_start, vecs[v].exp_fs);
            check($sformatf("v%0d_fcount", v), frame_count, vecs[v].exp_fc);
            check($sformatf("v%0d_lx", v), lyr.layer_x, vecs[v].x);
            check($sformatf("v%0d_ly", v), lyr.layer_y, vecs[v].y);
            wait_done(100, lat, mask);
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_color", v), color, vecs[v].exp_color);
            check($sformatf("v%0d_reqmask", v), mask, vecs[v].exp_mask);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_donepulse", v), color_done, 1'b0);
            check($sformatf("v%0d_idle", v), busy, 1'b0);
        end

        // Overrun: three edges during one fully timed-out query
        @(negedge clk);
        m_dly   = {8'hFF, 8'hFF, 8'hFF};
        m_opq   = '0;
        m_stray = '0;
        request(8'd7, 7'd7);
        repeat (3) @(posedge clk);
        @(negedge clk); x = 8'd9;  y = 7'd9;  np = 1'b1;
        @(negedge clk); np = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); x = 8'd11; y = 7'd11; np = 1'b1;
        @(negedge clk); np = 1'b0; x = 8'd9; y = 7'd9;
        @(posedge clk);
        #1;
        check("ovr_flag", overrun, 1'b1);
        check("ovr_busy", busy, 1'b1);
        wait_done(60, lat, mask);
        check("ovr_first_done", color_done, 1'b1);
        check("ovr_first_color", color, 16'h0000);
        @(posedge clk);
        #1;
        check("ovr_idle_gap", busy, 1'b0);
        @(posedge clk);
        #1;
        check("ovr_pending_busy", busy, 1'b1);
        check("ovr_pending_lx", lyr.layer_x, 8'd9);
        check("ovr_pending_ly", lyr.layer_y, 7'd9);
        check("ovr_pending_req", lyr.layer_req, 3'b001);
        wait_done(60, lat, mask);
        check("ovr_second_lat", lat, 48);
        repeat (5) @(posedge clk);
        #1;
        check("ovr_third_lost", busy, 1'b0);
        check("ovr_sticky", overrun, 1'b1);

        // Reset while layer 1 is being queried
        request(8'd20, 7'd10);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(posedge clk);
            #1;
            if (lyr.layer_req == 3'b010) found = 1'b1;
        end
        check("mid_reached_layer1", found, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_req", lyr.layer_req, 3'b000);
        check("mid_busy", busy, 1'b0);
        check("mid_fcount", frame_count, 16'd0);
        check("mid_overrun", overrun, 1'b0);
        check("mid_lx", lyr.layer_x, 8'd0);
        check("mid_done", color_done, 1'b0);
        @(posedge clk);
        #1;
        check("mid_done_held", color_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_dly = {8'hFF, 8'hFF, 8'd0};
        m_opq = 3'b001;
        m_col = {16'h0, 16'h0, 16'h0F0F};
        request(8'd1, 7'd1);
        check("post_req0", lyr.layer_req, 3'b001);
        wait_done(20, lat, mask);
        check("post_latency", lat, 1);
        check("post_color", color, 16'h0F0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
